i2s_rx: RTL
===========

Name: i2s_rx

Overview:
- Slave-mode I2S receiver for an external stereo ADC or codec line-in on a PMOD or the DAC header. It is the capture side of the top-level I2S audio generator.
- Samples externally driven BCLK, LRCK and DIN in the clk32 domain and deserialises one signed sample per channel.
- Presents a stereo pair with a one-cycle strobe to the audio mixer feeding the core's digital audio path.

Parameters:
- DATA_W, 16, sample width captured per channel (MSB first). Legal range 8..24.
- LJ, 0, 0 = Philips I2S (MSB one BCLK after LRCK edge); 1 = left-justified (MSB on first BCLK after LRCK edge).
- SYNC_STAGES, 2, synchroniser depth for bclk/lrck/din. Must be >= 2.

Ports:
- clk32  in  1  system clock, 32 MHz
- reset_n  in  1  asynchronous active-low reset
- i2s_bclk  in  1  external bit clock, async; must be <= clk32/4
- i2s_lrck  in  1  external word select; 0 = left, 1 = right
- i2s_din  in  1  serial data, valid on BCLK rising edge
- audio_l  out  DATA_W  last complete left sample, signed
- audio_r  out  DATA_W  last complete right sample, signed
- sample_stb  out  1  one-clk32 pulse; audio_l/audio_r updated this cycle
- locked  out  1  receiver aligned to a valid stream
- slot_err  out  1  sticky, set on a short slot; cleared by reset only

Behaviour:
- Reset values: audio_l = 0, audio_r = 0, sample_stb = 0, locked = 0, slot_err = 0, and all internal state cleared.
- Synchronisation and edge detection:
  - bclk, lrck and din each pass through SYNC_STAGES flops.
  - A BCLK rise is detected when the synced bclk is 1 and its previous value was 0.
  - lrck and din are sampled only on a detected rise. That is a fixed SYNC_STAGES+1 clk32 delay after the pin edge.
- Slot start:
  - An LRCK change seen on a rise marks a slot boundary.
  - Bit counter bcnt (6 bits) resets to 0 at the boundary. It saturates at 63 and increments on each rise.
  - With LJ = 0, the rise carrying the LRCK change is the last bit of the previous slot, so capture starts at the next rise.
  - With LJ = 1, capture starts at the rise carrying the change.
- Capture:
  - The first DATA_W bits of a slot are shifted MSB first into shift register sr.
  - Bits beyond DATA_W within a slot are ignored. Slots up to 32 bits are supported.
- State machine: SEARCH, LEFT, RIGHT.
  - SEARCH: wait for a 1->0 LRCK transition, then go to LEFT. Outputs are not updated in this state.
  - LEFT: when DATA_W bits are captured, hold them in l_hold. On the 0->1 boundary, go to RIGHT.
  - RIGHT: when DATA_W bits are captured, load audio_l <= l_hold and audio_r <= sr, and pulse sample_stb (1 clk32). On the 1->0 boundary, go to LEFT.
  - Latency: sample_stb occurs in the clk32 cycle after the rise that captures the last right-channel bit.
- Short slot: a boundary that arrives before DATA_W bits are captured in the current slot causes the following:
  - slot_err <= 1 and locked <= 0.
  - That frame's strobe is suppressed.
  - FSM re-enters LEFT (on a 1->0 change) or SEARCH (on a 0->1 change).
- Lock: locked sets after 2 consecutive error-free frames (two sample_stb pulses without an intervening short slot). It stays set until a short slot or a timeout.
- Output hold: audio_l and audio_r hold their values between strobes, and also while unlocked.
- Reset mid-frame: asynchronous clear of all state; after release, the FSM restarts in SEARCH.
- No BCLK edges: the FSM simply stalls and no strobe is produced (see the optional feature).

Optional Feature:
- Macro: I2S_RX_TIMEOUT_EN.
- Defined:
  - A 10-bit counter counts clk32 cycles since the last BCLK rise.
  - When it reaches 1023, the block does the following: locked <= 0, audio_l and audio_r <= 0, one sample_stb pulse so downstream latches silence, FSM goes to SEARCH.
  - The counter then holds until the next rise, so no repeated strobes.
- Undefined:
  - No counter.
  - Outputs hold their last sample indefinitely on clock loss.

Test Plan:
- Basic capture: reset, then drive 1.536 MHz BCLK with 32 BCLK/frame, LJ = 0, L = 16'h1234, R = 16'hA5C3 for 3 frames → sample_stb once per frame with audio_l = 16'h1234 and audio_r = 16'hA5C3; locked rises after the 2nd strobe; slot_err = 0.
- Left-justified and long slot: LJ = 1, 64 BCLK/frame (32-bit slots), L = 16'h8000, R = 16'h7FFF → outputs match; trailing bits ignored; one strobe per frame.
- Short slot: after lock, toggle LRCK after only 10 bits of a right slot → slot_err = 1, locked = 0, no strobe for that frame; relock after 2 further good frames, with slot_err still 1.
- Reset mid-frame: assert reset_n = 0 at bit 7 of a left slot → all outputs 0 immediately; after release, the first strobe occurs only after a full LEFT+RIGHT frame following a 1->0 LRCK change.
- Timeout (I2S_RX_TIMEOUT_EN defined): stop BCLK while locked with L/R = 16'h1234/16'hA5C3 → after 1023 clk32 cycles, exactly one sample_stb with audio_l = audio_r = 0 and locked = 0; with the macro undefined, outputs stay 16'h1234/16'hA5C3 and locked stays 1.
- Synchroniser margin: BCLK = clk32/4 with din toggling every bit (alternating 1010…) → audio_l = 16'hAAAA with no bit slips over 100 frames.

Source files
------------

// File: rtl/i2s_rx.sv
// Slave-mode I2S / left-justified stereo receiver sampled in the clk32 domain.
// Optional clock-loss timeout is enabled by defining I2S_RX_TIMEOUT_EN.
module i2s_rx #(
  parameter int DATA_W      = 16,
  parameter int LJ          = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk32,
  input  logic              reset_n,
  input  logic              i2s_bclk,
  input  logic              i2s_lrck,
  input  logic              i2s_din,
  output logic [DATA_W-1:0] audio_l,
  output logic [DATA_W-1:0] audio_r,
  output logic              sample_stb,
  output logic              locked,
  output logic              slot_err
);

  localparam int          TOP       = SYNC_STAGES - 1;
  localparam logic [5:0]  DW6       = 6'(DATA_W);
  localparam logic [5:0]  DW_M1     = 6'(DATA_W - 1);
  localparam logic [1:0]  ST_SEARCH = 2'd0;
  localparam logic [1:0]  ST_LEFT   = 2'd1;
  localparam logic [1:0]  ST_RIGHT  = 2'd2;

  logic [SYNC_STAGES-1:0] bclk_sync_r;
  logic [SYNC_STAGES-1:0] lrck_sync_r;
  logic [SYNC_STAGES-1:0] din_sync_r;
  logic                   bclk_prev_r;
  logic                   lrck_last_r;
  logic [5:0]             bcnt_r;
  logic [DATA_W-1:0]      sr_r;
  logic [DATA_W-1:0]      l_hold_r;
  logic [1:0]             state_r;
  logic                   good_r;

  logic                   rise_s;
  logic                   boundary_s;
  logic                   lrck_now_s;
  logic                   din_now_s;
  logic                   cap_s;
  logic                   done_s;
  logic                   short_s;
  logic [5:0]             bcnt_next_s;
  logic [DATA_W-1:0]      sr_next_s;
  logic                   to_fire_s;

  // Input synchronisers and bclk edge history
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync_r <= {SYNC_STAGES{1'b0}};
      lrck_sync_r <= {SYNC_STAGES{1'b0}};
      din_sync_r  <= {SYNC_STAGES{1'b0}};
      bclk_prev_r <= 1'b0;
    end else begin
      bclk_sync_r <= {bclk_sync_r[SYNC_STAGES-2:0], i2s_bclk};
      lrck_sync_r <= {lrck_sync_r[SYNC_STAGES-2:0], i2s_lrck};
      din_sync_r  <= {din_sync_r[SYNC_STAGES-2:0], i2s_din};
      bclk_prev_r <= bclk_sync_r[TOP];
    end
  end

  assign lrck_now_s = lrck_sync_r[TOP];
  assign din_now_s  = din_sync_r[TOP];
  assign rise_s     = bclk_sync_r[TOP] & ~bclk_prev_r;
  assign boundary_s = rise_s & (lrck_now_s != lrck_last_r);

  // Per-rise capture decision; in Philips mode the boundary rise still carries the previous slot's LSB
  always_comb begin
    sr_next_s   = {sr_r[DATA_W-2:0], din_now_s};
    cap_s       = 1'b0;
    done_s      = 1'b0;
    short_s     = 1'b0;
    bcnt_next_s = bcnt_r;
    if (boundary_s) begin
      if (LJ == 1) begin
        short_s     = (bcnt_r < DW6);
        cap_s       = 1'b1;
        bcnt_next_s = 6'd1;
      end else begin
        short_s     = (bcnt_r < DW_M1);
        cap_s       = (bcnt_r < DW6);
        done_s      = (bcnt_r == DW_M1);
        bcnt_next_s = 6'd0;
      end
    end else if (rise_s) begin
      cap_s       = (bcnt_r < DW6);
      done_s      = (bcnt_r == DW_M1);
      bcnt_next_s = (bcnt_r == 6'd63) ? 6'd63 : bcnt_r + 6'd1;
    end else begin
      bcnt_next_s = bcnt_r;
    end
  end

`ifdef I2S_RX_TIMEOUT_EN
  logic [9:0] to_cnt_r;

  assign to_fire_s = ~rise_s & (to_cnt_r == 10'd1022);

  // Cycles since last bclk rise; parks at 1023 so silence is strobed only once
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_r <= 10'd0;
    end else if (rise_s) begin
      to_cnt_r <= 10'd0;
    end else if (to_cnt_r != 10'd1023) begin
      to_cnt_r <= to_cnt_r + 10'd1;
    end else begin
      to_cnt_r <= to_cnt_r;
    end
  end
`else
  assign to_fire_s = 1'b0;
`endif

  // Framing FSM, shift register, outputs and lock tracking
  always_ff @(posedge clk32 or negedge reset_n) begin
    if (!reset_n) begin
      lrck_last_r <= 1'b0;
      bcnt_r      <= 6'd0;
      sr_r        <= {DATA_W{1'b0}};
      l_hold_r    <= {DATA_W{1'b0}};
      state_r     <= ST_SEARCH;
      good_r      <= 1'b0;
      audio_l     <= {DATA_W{1'b0}};
      audio_r     <= {DATA_W{1'b0}};
      sample_stb  <= 1'b0;
      locked      <= 1'b0;
      slot_err    <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      if (rise_s) begin
        lrck_last_r <= lrck_now_s;
        bcnt_r      <= bcnt_next_s;
      end
      if (cap_s) begin
        sr_r <= sr_next_s;
      end
      case (state_r)
        ST_SEARCH: begin
          if (boundary_s && !lrck_now_s) begin
            state_r <= ST_LEFT;
          end
        end
        ST_LEFT, ST_RIGHT: begin
          if (done_s && (state_r == ST_LEFT)) begin
            l_hold_r <= sr_next_s;
          end
          if (done_s && (state_r == ST_RIGHT)) begin
            audio_l    <= l_hold_r;
            audio_r    <= sr_next_s;
            sample_stb <= 1'b1;
            good_r     <= 1'b1;
            if (good_r) begin
              locked <= 1'b1;
            end
          end
          if (boundary_s) begin
            if (short_s) begin
              slot_err <= 1'b1;
              locked   <= 1'b0;
              good_r   <= 1'b0;
              state_r  <= lrck_now_s ? ST_SEARCH : ST_LEFT;
            end else begin
              state_r  <= lrck_now_s ? ST_RIGHT : ST_LEFT;
            end
          end
        end
        default: state_r <= ST_SEARCH;
      endcase
      // Clock loss: flush silence downstream once and re-acquire framing
      if (to_fire_s) begin
        locked     <= 1'b0;
        good_r     <= 1'b0;
        audio_l    <= {DATA_W{1'b0}};
        audio_r    <= {DATA_W{1'b0}};
        sample_stb <= 1'b1;
        state_r    <= ST_SEARCH;
      end
    end
  end

endmodule
